// File: rtl/ps2_wasd_decoder_pkg.sv
// Shared scan-code constants and receiver state encodings for the PS/2 WASD decoder.
// Optional arrow-key support is enabled by defining PS2_ARROW_KEYS_EN.
package ps2_wasd_decoder_pkg;

   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rxState_t;

endpackage

// File: rtl/ps2_wasd_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, framing FSM, odd parity and abort timeout.
// Strobes rxGood/rxBad combinationally in the cycle the stop bit (or timeout) is seen.
module ps2_frame_rx
   import ps2_wasd_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       rxGood,
   output logic       rxBad,
   output logic [7:0] rxByte
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic           clkS1_q, clkS2_q, clkPrev_q;
   logic           dataS1_q, dataS2_q;
   rxState_t       state_q, state_d;
   logic [2:0]     bitCnt_q, bitCnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           parity_q, parity_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           fall;

   // Synchronizers idle high so reset never fakes a falling edge
   always_ff @(posedge clk_25MHz or negedge reset) begin
      if (!reset) begin
         clkS1_q   <= 1'b1;
         clkS2_q   <= 1'b1;
         clkPrev_q <= 1'b1;
         dataS1_q  <= 1'b1;
         dataS2_q  <= 1'b1;
      end else begin
         clkS1_q   <= ps2_clk;
         clkS2_q   <= clkS1_q;
         clkPrev_q <= clkS2_q;
         dataS1_q  <= ps2_data;
         dataS2_q  <= dataS1_q;
      end
   end

   assign fall   = clkPrev_q & ~clkS2_q;
   assign rxByte = shift_q;

   always_ff @(posedge clk_25MHz or negedge reset) begin
      if (!reset) begin
         state_q  <= RX_IDLE;
         bitCnt_q <= 3'd0;
         shift_q  <= 8'h00;
         parity_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         timer_q  <= timer_d;
      end
   end

   // Timer restarts on every falling edge and only runs inside a frame
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      rxGood   = 1'b0;
      rxBad    = 1'b0;
      if (state_q == RX_IDLE || fall) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      case (state_q)
         RX_IDLE: begin
            if (fall && !dataS2_q) begin
               state_d  = RX_DATA;
               bitCnt_d = 3'd0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_d  = {dataS2_q, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  state_d = RX_PARITY;
               end
            end
         end
         RX_PARITY: begin
            if (fall) begin
               parity_d = dataS2_q;
               state_d  = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               state_d = RX_IDLE;
               if (dataS2_q && (^shift_q ^ parity_q)) begin
                  rxGood = 1'b1;
               end else begin
                  rxBad = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase

      if (state_q != RX_IDLE && !fall && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = RX_IDLE;
         timer_d = '0;
         rxBad   = 1'b1;
      end
   end

endmodule

// File: rtl/ps2_wasd_decoder.sv
// PS/2 keyboard decoder producing held levels for W/A/S/D from make/break scan codes.
// Define PS2_ARROW_KEYS_EN to let the extended arrow keys also drive w/a/s/d.
module ps2_wasd_decoder
   import ps2_wasd_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       w,
   output logic       a,
   output logic       s,
   output logic       d,
   output logic [7:0] scan_code,
   output logic       frame_valid,
   output logic       frame_error
);

   logic       rxGood, rxBad;
   logic [7:0] rxByte;

   logic       valid_q, valid_d, error_q, error_d;
   logic [7:0] scan_q, scan_d;
   logic       break_q, break_d, ext_q, ext_d;
   logic       wKey_q, wKey_d, aKey_q, aKey_d, sKey_q, sKey_d, dKey_q, dKey_d;
`ifdef PS2_ARROW_KEYS_EN
   logic       upKey_q, upKey_d, leftKey_q, leftKey_d;
   logic       downKey_q, downKey_d, rightKey_q, rightKey_d;
`endif

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk_25MHz(clk_25MHz),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rxGood   (rxGood),
      .rxBad    (rxBad),
      .rxByte   (rxByte)
   );

   // Prefix bytes accumulate in flags; any other good byte consumes them
   always_comb begin
      valid_d = rxGood;
      error_d = rxBad;
      scan_d  = scan_q;
      break_d = break_q;
      ext_d   = ext_q;
      wKey_d  = wKey_q;
      aKey_d  = aKey_q;
      sKey_d  = sKey_q;
      dKey_d  = dKey_q;
`ifdef PS2_ARROW_KEYS_EN
      upKey_d    = upKey_q;
      leftKey_d  = leftKey_q;
      downKey_d  = downKey_q;
      rightKey_d = rightKey_q;
`endif
      if (rxBad) begin
         break_d = 1'b0;
         ext_d   = 1'b0;
      end else if (rxGood) begin
         scan_d = rxByte;
         if (rxByte == SC_BREAK) begin
            break_d = 1'b1;
         end else if (rxByte == SC_EXT) begin
            ext_d = 1'b1;
         end else begin
            if (!ext_q) begin
               case (rxByte)
                  SC_W:    wKey_d = ~break_q;
                  SC_A:    aKey_d = ~break_q;
                  SC_S:    sKey_d = ~break_q;
                  SC_D:    dKey_d = ~break_q;
                  default: ;
               endcase
            end
`ifdef PS2_ARROW_KEYS_EN
            else begin
               case (rxByte)
                  SC_UP:    upKey_d    = ~break_q;
                  SC_LEFT:  leftKey_d  = ~break_q;
                  SC_DOWN:  downKey_d  = ~break_q;
                  SC_RIGHT: rightKey_d = ~break_q;
                  default:  ;
               endcase
            end
`endif
            break_d = 1'b0;
            ext_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_25MHz or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         scan_q  <= 8'h00;
         break_q <= 1'b0;
         ext_q   <= 1'b0;
         wKey_q  <= 1'b0;
         aKey_q  <= 1'b0;
         sKey_q  <= 1'b0;
         dKey_q  <= 1'b0;
`ifdef PS2_ARROW_KEYS_EN
         upKey_q    <= 1'b0;
         leftKey_q  <= 1'b0;
         downKey_q  <= 1'b0;
         rightKey_q <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         error_q <= error_d;
         scan_q  <= scan_d;
         break_q <= break_d;
         ext_q   <= ext_d;
         wKey_q  <= wKey_d;
         aKey_q  <= aKey_d;
         sKey_q  <= sKey_d;
         dKey_q  <= dKey_d;
`ifdef PS2_ARROW_KEYS_EN
         upKey_q    <= upKey_d;
         leftKey_q  <= leftKey_d;
         downKey_q  <= downKey_d;
         rightKey_q <= rightKey_d;
`endif
      end
   end

   assign frame_valid = valid_q;
   assign frame_error = error_q;
   assign scan_code   = scan_q;
`ifdef PS2_ARROW_KEYS_EN
   assign w = wKey_q | upKey_q;
   assign a = aKey_q | leftKey_q;
   assign s = sKey_q | downKey_q;
   assign d = dKey_q | rightKey_q;
`else
   assign w = wKey_q;
   assign a = aKey_q;
   assign s = sKey_q;
   assign d = dKey_q;
`endif

endmodule

// File: tb/tb_ps2_wasd_decoder.sv
// Scoreboard bench for ps2_wasd_decoder: each sent frame queues its expected pulse, scan code and keys.
// Expectations for the arrow-key sequence follow PS2_ARROW_KEYS_EN when it is defined.
module tb_ps2_wasd_decoder;

   localparam int HALF = 20;

   typedef struct {
      logic       isErr;
      logic [7:0] scan;
      logic [3:0] keys;
   } expect_t;

   logic       clk_25MHz = 1'b0;
   logic       reset     = 1'b0;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic       w, a, s, d;
   logic [7:0] scan_code;
   logic       frame_valid, frame_error;

   expect_t    sb[$];
   logic [7:0] lastScan = 8'h00;
   int         total = 0;
   int         bad   = 0;

   ps2_wasd_decoder dut (
      .clk_25MHz  (clk_25MHz),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .w          (w),
      .a          (a),
      .s          (s),
      .d          (d),
      .scan_code  (scan_code),
      .frame_valid(frame_valid),
      .frame_error(frame_error)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic ps2Bit(input logic v);
      ps2_data = v;
      repeat (HALF) @(negedge clk_25MHz);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk_25MHz);
      ps2_clk = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic badParity, input logic badStop);
      ps2Bit(1'b0);
      for (int i = 0; i < 8; i++) ps2Bit(b[i]);
      ps2Bit(~(^b) ^ badParity);
      ps2Bit(~badStop);
      ps2_data = 1'b1;
      repeat (100) @(negedge clk_25MHz);
   endtask

   // keys are packed {w,a,s,d} as they must read once this byte is decoded
   task automatic applyStimulus(input logic [7:0] b, input logic [3:0] keys);
      expect_t e;
      e.isErr = 1'b0;
      e.scan  = b;
      e.keys  = keys;
      sb.push_back(e);
      lastScan = b;
      sendFrame(b, 1'b0, 1'b0);
   endtask

   task automatic sendBad(input logic [7:0] b, input logic badParity, input logic badStop,
                          input logic [3:0] keys);
      expect_t e;
      e.isErr = 1'b1;
      e.scan  = lastScan;
      e.keys  = keys;
      sb.push_back(e);
      sendFrame(b, badParity, badStop);
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk_25MHz);
         n++;
      end
      checkOutput(tag, sb.size(), 0);
      sb.delete();
   endtask

   // Pulses are compared on the falling edge, half a cycle after they are registered
   always @(negedge clk_25MHz) begin
      if (reset && (frame_valid || frame_error)) begin
         if (sb.size() == 0) begin
            checkOutput("unexpectedPulse", {frame_valid, frame_error}, 0);
         end else begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("pulseKind", {frame_valid, frame_error}, e.isErr ? 2'b01 : 2'b10);
            checkOutput("scanCode", scan_code, e.scan);
            checkOutput("keysWASD", {w, a, s, d}, e.keys);
         end
      end
   end

   initial begin
      repeat (5) @(negedge clk_25MHz);
      checkOutput("resetOutputs", {w, a, s, d, frame_valid, frame_error, scan_code}, 0);
      reset = 1'b1;
      repeat (5) @(negedge clk_25MHz);

      // W make then release
      applyStimulus(8'h1D, 4'b1000);
      applyStimulus(8'hF0, 4'b1000);
      applyStimulus(8'h1D, 4'b0000);

      // A and D together, then release A only
      applyStimulus(8'h1C, 4'b0100);
      applyStimulus(8'h23, 4'b0101);
      applyStimulus(8'hF0, 4'b0101);
      applyStimulus(8'h1C, 4'b0001);

      // Bad parity and bad stop leave keys and scan code alone
      sendBad(8'h1B, 1'b1, 1'b0, 4'b0001);
      sendBad(8'h1B, 1'b0, 1'b1, 4'b0001);

      // Break flag cleared by the error: the following 0x23 is a make, D stays held
      applyStimulus(8'hF0, 4'b0001);
      sendBad(8'h23, 1'b1, 1'b0, 4'b0001);
      applyStimulus(8'h23, 4'b0001);

      // Typematic repeat, release of an unheld key, unmapped byte
      applyStimulus(8'h1B, 4'b0011);
      applyStimulus(8'h1B, 4'b0011);
      applyStimulus(8'hF0, 4'b0011);
      applyStimulus(8'h1D, 4'b0011);
      applyStimulus(8'h15, 4'b0011);
      applyStimulus(8'hF0, 4'b0011);
      applyStimulus(8'h1B, 4'b0001);
      applyStimulus(8'hF0, 4'b0001);
      applyStimulus(8'h23, 4'b0000);
      waitDrain("drainBasic", 2000);

      // Extended / arrow sequence
      applyStimulus(8'h1D, 4'b1000);
      applyStimulus(8'hE0, 4'b1000);
      applyStimulus(8'h75, 4'b1000);
      applyStimulus(8'hF0, 4'b1000);
`ifdef PS2_ARROW_KEYS_EN
      applyStimulus(8'h1D, 4'b1000);
`else
      applyStimulus(8'h1D, 4'b0000);
`endif
      applyStimulus(8'hE0, 4'b0000 | {w, 3'b000});
      applyStimulus(8'hF0, 4'b0000 | {w, 3'b000});
      applyStimulus(8'h75, 4'b0000);
      // Extended byte equal to W code must not touch w
      applyStimulus(8'hE0, 4'b0000);
      applyStimulus(8'h1D, 4'b0000);
      waitDrain("drainExt", 2000);

      // Abandoned frame: start plus four data bits, then silence
      begin
         expect_t e;
         e.isErr = 1'b1;
         e.scan  = lastScan;
         e.keys  = 4'b0000;
         sb.push_back(e);
      end
      ps2Bit(1'b0);
      for (int i = 0; i < 4; i++) ps2Bit(1'b1);
      ps2_data = 1'b1;
      repeat (20000) @(negedge clk_25MHz);
      checkOutput("noEarlyTimeout", sb.size(), 1);
      waitDrain("timeoutSeen", 10000);
      applyStimulus(8'h1D, 4'b1000);
      applyStimulus(8'hF0, 4'b1000);
      applyStimulus(8'h1D, 4'b0000);

      // Reset in the middle of a frame while A is held
      applyStimulus(8'h1C, 4'b0100);
      waitDrain("drainPreReset", 2000);
      ps2Bit(1'b0);
      for (int i = 0; i < 3; i++) ps2Bit(1'b0);
      #3 reset = 1'b0;
      #2 checkOutput("midFrameReset", {w, a, s, d, frame_valid, frame_error, scan_code}, 0);
      lastScan = 8'h00;
      repeat (10) @(negedge clk_25MHz);
      ps2_data = 1'b1;
      reset = 1'b1;
      repeat (10) @(negedge clk_25MHz);
      applyStimulus(8'h1C, 4'b0100);
      waitDrain("drainFinal", 2000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
